// File: rtl/j_i2s_rxsync.sv
// I2S slave receive front end: synchronises sck/ws/sd into sys_clk,
// assembles MSB-first words per channel and emits load strobes.
module j_i2s_rxsync #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             ws,
  input  logic             sd,
  input  logic             en,
  output logic [WIDTH-1:0] ldata,
  output logic [WIDTH-1:0] rdata,
  output logic             lld,
  output logic             rld,
  output logic             short,
  output logic             locked
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [WIDTH-1:0] MSB_M = {1'b1, {(WIDTH-1){1'b0}}};

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] ws_q;
  logic [SYNC_STAGES-1:0] sd_q;
  logic                   sck_d;

  logic [1:0]       state;
  logic [WIDTH-1:0] wreg;
  logic [CW-1:0]    cnt;
  logic             ws_p;

  logic             sck_s;
  logic             ws_s;
  logic             sd_s;
  logic             se;
  logic             ws_chg;
  logic             full;
  logic             short_nx;
  logic [WIDTH-1:0] bit_m;
  logic [WIDTH-1:0] word_nx;

  // Equal-depth chains keep sck, ws and sd mutually aligned.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sck_q <= '0;
      ws_q  <= '0;
      sd_q  <= '0;
      sck_d <= 1'b0;
    end else begin
      sck_q <= {sck_q[SYNC_STAGES-2:0], sck};
      ws_q  <= {ws_q[SYNC_STAGES-2:0], ws};
      sd_q  <= {sd_q[SYNC_STAGES-2:0], sd};
      sck_d <= sck_s;
    end
  end

  assign sck_s  = sck_q[SYNC_STAGES-1];
  assign ws_s   = ws_q[SYNC_STAGES-1];
  assign sd_s   = sd_q[SYNC_STAGES-1];
  assign se     = sck_s & ~sck_d;
  assign ws_chg = ws_s ^ ws_p;

  // Mask is all-zero once cnt saturates, so extra bits fall away.
  assign full     = (cnt == CW'(WIDTH));
  assign bit_m    = MSB_M >> cnt;
  assign word_nx  = sd_s ? (wreg | bit_m) : wreg;
  assign short_nx = (cnt < CW'(WIDTH - 1));

  assign locked = (state == S_RUN);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      wreg  <= '0;
      cnt   <= '0;
      ws_p  <= 1'b0;
      ldata <= '0;
      rdata <= '0;
      lld   <= 1'b0;
      rld   <= 1'b0;
      short <= 1'b0;
    end else begin
      lld   <= 1'b0;
      rld   <= 1'b0;
      short <= 1'b0;
      if (se) ws_p <= ws_s;
      unique case (state)
        S_IDLE: begin
          wreg <= '0;
          cnt  <= '0;
          if (en) state <= S_SYNC;
        end
        S_SYNC: begin
          if (!en) begin
            state <= S_IDLE;
          end else if (se && ws_chg) begin
            wreg  <= '0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!en) begin
            state <= S_IDLE;
            wreg  <= '0;
            cnt   <= '0;
          end else if (se) begin
            if (ws_chg) begin
              // Current bit is the LSB of the ws_p channel.
              if (ws_p) begin
                rdata <= word_nx;
                rld   <= 1'b1;
              end else begin
                ldata <= word_nx;
                lld   <= 1'b1;
              end
              short <= short_nx;
              wreg  <= '0;
              cnt   <= '0;
            end else begin
              wreg <= word_nx;
              if (!full) cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/j_i2s_rxsync.md
# j_i2s_rxsync

Serial-audio front end for Jerry's I2S slave receive path. It brings the externally clocked SCK/WS/SD lines into the sys_clk domain and detects SCK rising edges. It assembles MSB-first words per channel and issues one-cycle load strobes with the parallel word. Those strobes are the `ld`/`d` inputs of the load-enabled holding latches (j_fdsynch-style `fd1e` cells) that follow this stage.

## Interface
- WIDTH, 16: word width delivered per channel (8..32).
- SYNC_STAGES, 2: synchroniser depth applied identically to sck, ws and sd (≥2).

- sys_clk  in  1  sole clock; all flops rise on sys_clk.
- reset  in  1  asynchronous, active-high; clears all state.
- sck  in  1  external serial bit clock, asynchronous to sys_clk.
- ws  in  1  external word select; 0 = left, 1 = right.
- sd  in  1  external serial data, MSB first.
- en  in  1  receiver enable (sys_clk domain).
- ldata  out  WIDTH  last completed left word.
- rdata  out  WIDTH  last completed right word.
- lld  out  1  one-cycle strobe; ldata updated this cycle.
- rld  out  1  one-cycle strobe; rdata updated this cycle.
- short  out  1  one-cycle strobe alongside lld/rld when the word had fewer than WIDTH bits.
- locked  out  1  high in RUN state.

## Operation
- Synchronisers: sck, ws and sd each pass through SYNC_STAGES flops, so the three stay mutually aligned.
- Sample event (SE): a cycle where synced sck = 1 and its previous-cycle value = 0. Only SEs touch datapath state.
- Registers:
  - wreg[WIDTH-1:0]: word being assembled.
  - cnt: bit index, saturating at WIDTH.
  - ws_p: ws captured at the previous SE.
- Per SE, in RUN:
  - If cnt < WIDTH, wreg[WIDTH-1-cnt] <= sd_s and cnt increments. Otherwise the bit is dropped and cnt holds (truncation).
  - If ws_s ≠ ws_p, the current bit is the LSB of channel ws_p's word (I2S one-bit WS lead). The completed word is written to ldata (ws_p=0) or rdata (ws_p=1) with the current bit included. The matching strobe fires. short = (bits received < WIDTH), with low bits zero-padded. wreg and cnt then clear for the next word.
  - ws_p <= ws_s on every SE.
- State machine:
  - IDLE: entered on reset or en=0. wreg/cnt held clear; no strobes.
  - IDLE → SYNC when en=1.
  - SYNC: SEs update ws_p only. The first SE with ws_s ≠ ws_p clears wreg/cnt and goes to RUN. The partial word is discarded; no strobe.
  - RUN → IDLE immediately whenever en=0. The partial word is discarded; ldata/rdata keep their last values.
- lld and rld are never high together. A WS change is always attributed to exactly one channel.

## Timing
- Reset values: ldata=0, rdata=0, lld=0, rld=0, short=0, locked=0, state IDLE, ws_p=0, cnt=0, wreg=0.
- SE cycle = SYNC_STAGES+1 sys_clk after an sck rising edge meets setup.
- Output update: ldata/rdata and strobes are registered in the cycle after the SE, so lld/rld/short are high exactly one cycle. Data stays stable until the same channel's next strobe.
- locked rises the cycle after the SYNC→RUN SE and falls the cycle after en=0 is seen.
- sys_clk must be ≥4× sck. sck high and low each ≥2 sys_clk.
- sd and ws must be stable around the sck rising edge, as in standard I2S.
- Reset asserted mid-word: all state clears asynchronously and no strobe is emitted. After release, the block re-enters SYNC only if en=1.

## Test plan
- Reset: assert reset mid-stream -> all outputs 0 immediately. Release with en=0 -> no strobes over 100 SCKs.
- WIDTH=16 stereo, left=0xA5C3, right=0x1234, 3 frames after lock:
  - lld with ldata=0xA5C3 one cycle after the SE of the left LSB.
  - rld with rdata=0x1234 likewise.
  - short=0 throughout; first partial frame produces no strobe.
- 18-bit words (left=0x2AAAA) at WIDTH=16 -> ldata=0xAAAA (top 16 bits), short=0.
- 12-bit words (left=0xABC) at WIDTH=16 -> ldata=0xABC0, short=1 with lld.
- Drop en mid-right word, re-raise 5 SCKs later:
  - locked falls and no rld for the partial word.
  - rdata keeps its last value.
  - After the next WS edge, correct words resume.
- SYNC_STAGES=3, sck at exactly 4× ratio -> identical words to the SYNC_STAGES=2 run. Strobes shift one cycle later.
